// File: rtl/irq_pend_if.sv
// Pend/take handshake between an interrupt source block and the CLIC.
//   pend_valid  initiator -> CLIC  request presented
//   pend_id     initiator -> CLIC  source id of the presented request
//   pend_ready  CLIC -> initiator  request accepted this cycle
//   take_valid  CLIC -> initiator  an interrupt was taken this cycle
//   take_id     CLIC -> initiator  id of the taken interrupt
interface irq_pend_if #(
  parameter int IdWidth = 3
) ();
  logic               pend_valid;
  logic [IdWidth-1:0] pend_id;
  logic               pend_ready;
  logic               take_valid;
  logic [IdWidth-1:0] take_id;

  modport master (
    output pend_valid, pend_id,
    input  pend_ready, take_valid, take_id
  );

  modport slave (
    input  pend_valid, pend_id,
    output pend_ready, take_valid, take_id
  );
endinterface

// File: rtl/irq_pend_source.sv
// Initiator side of the CLIC pend interface.
// Samples NumSrc interrupt lines (edge or level per source), tracks every source
// through IDLE/REQ/SENT, presents one pend request at a time chosen round-robin,
// and retires a source when the CLIC reports it taken.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   irq_in       interrupt lines, already synchronous to clk
//   edge_mode    per source: 1 = rising-edge trigger, 0 = level trigger
//   src_enable   per source enable; 0 blocks new triggers
//   ovf_clear    clears the sticky overflow flag
//   overflow     sticky: a trigger was coalesced into an outstanding source
//   outstanding  per source: state != IDLE
//   pend         pend/take handshake (master side)
module irq_pend_source #(
  parameter int NumSrc  = 8,
  parameter int IdWidth = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NumSrc-1:0] irq_in,
  input  logic [NumSrc-1:0] edge_mode,
  input  logic [NumSrc-1:0] src_enable,
  input  logic              ovf_clear,
  output logic              overflow,
  output logic [NumSrc-1:0] outstanding,
  irq_pend_if.master        pend
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_SENT = 2'd2
  } src_state_e;

  src_state_e         state_q [NumSrc];
  src_state_e         state_d [NumSrc];
  logic [NumSrc-1:0]  irq_prev;
  logic [IdWidth-1:0] rr_ptr;
  logic               pend_valid_q;
  logic [IdWidth-1:0] pend_id_q;
  logic               overflow_q;

  logic [NumSrc-1:0]  trig;
  logic [NumSrc-1:0]  presented;
  logic [NumSrc-1:0]  take_hit;
  logic [NumSrc-1:0]  cand;
  logic               accept;
  logic               search;
  logic               found;
  logic [IdWidth-1:0] sel;
  logic               ovf_set;

  assign pend.pend_valid = pend_valid_q;
  assign pend.pend_id    = pend_id_q;
  assign overflow        = overflow_q;

  assign accept = pend_valid_q && pend.pend_ready;
  // The bus is free to load a new request when idle or when the current one
  // is being accepted this cycle.
  assign search = !pend_valid_q || accept;

  assign trig = src_enable & ((edge_mode & irq_in & ~irq_prev) | (~edge_mode & irq_in));

  always_comb begin
    for (int i = 0; i < NumSrc; i++) begin
      outstanding[i] = (state_q[i] != S_IDLE);
      presented[i]   = pend_valid_q && (pend_id_q == IdWidth'(i));
      // take_id values >= NumSrc never match any i and are ignored.
      take_hit[i]    = pend.take_valid && (pend.take_id == IdWidth'(i));
      // A disabled REQ source is leaving this cycle, and the source being
      // accepted is leaving REQ, so neither may be selected.
      cand[i]        = (state_q[i] == S_REQ) && src_enable[i] && !(presented[i] && accept);
    end
  end

  // Per-source state transitions and coalescing detection.
  always_comb begin
    ovf_set = 1'b0;
    for (int i = 0; i < NumSrc; i++) begin
      state_d[i] = state_q[i];
      unique case (state_q[i])
        S_IDLE: begin
          if (trig[i]) state_d[i] = S_REQ;
        end
        S_REQ: begin
          if (presented[i] && accept)              state_d[i] = S_SENT;
          else if (!src_enable[i] && !presented[i]) state_d[i] = S_IDLE;
          // A held level line is the same request, not a new one.
          if (trig[i] && edge_mode[i]) ovf_set = 1'b1;
        end
        S_SENT: begin
          if (take_hit[i])                      state_d[i] = trig[i] ? S_REQ : S_IDLE;
          else if (trig[i] && edge_mode[i])     ovf_set = 1'b1;
        end
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  // Round-robin search starting at rr_ptr, wrapping at NumSrc-1.
  always_comb begin
    int idx;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NumSrc; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NumSrc) idx = idx - NumSrc;
      if (!found && cand[idx]) begin
        found = 1'b1;
        sel   = IdWidth'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NumSrc; i++) state_q[i] <= S_IDLE;
      pend_valid_q <= 1'b0;
      pend_id_q    <= '0;
      overflow_q   <= 1'b0;
      rr_ptr       <= '0;
      // Tracking the lines during reset means a line already high at release
      // is not seen as a rising edge.
      irq_prev     <= irq_in;
    end else begin
      for (int i = 0; i < NumSrc; i++) state_q[i] <= state_d[i];
      irq_prev <= irq_in;

      if (ovf_set)        overflow_q <= 1'b1;
      else if (ovf_clear) overflow_q <= 1'b0;

      if (search) begin
        if (found) begin
          pend_valid_q <= 1'b1;
          pend_id_q    <= sel;
          if (int'(sel) == NumSrc - 1) rr_ptr <= '0;
          else                         rr_ptr <= sel + 1'b1;
        end else begin
          pend_valid_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_irq_pend_source.sv
// Bench for irq_pend_source: directed scenarios followed by randomized traffic,
// all checked each cycle against a behavioural model of the source table.
module tb_irq_pend_source;

  localparam int NS = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [NS-1:0] irq_in, edge_mode, src_enable;
  logic          ovf_clear;
  logic          overflow;
  logic [NS-1:0] outstanding;

  irq_pend_if #(.IdWidth(IW)) pif ();

  irq_pend_source #(.NumSrc(NS), .IdWidth(IW)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .edge_mode  (edge_mode),
    .src_enable (src_enable),
    .ovf_clear  (ovf_clear),
    .overflow   (overflow),
    .outstanding(outstanding),
    .pend       (pif)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: 0 = idle, 1 = requested, 2 = sent.
  int m_st [NS];
  bit m_pv;
  int m_pid;
  bit m_ovf;
  int m_rr;
  bit m_prev [NS];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int  nst [NS];
    bit  acc, set_ovf, found, trig, take, pres;
    int  sel, j;
    if (reset) begin
      for (int i = 0; i < NS; i++) begin
        m_st[i]   = 0;
        m_prev[i] = irq_in[i];
      end
      m_pv = 0; m_pid = 0; m_ovf = 0; m_rr = 0;
      return;
    end
    acc     = m_pv && pif.pend_ready;
    set_ovf = 0;
    for (int i = 0; i < NS; i++) begin
      trig   = src_enable[i] && (edge_mode[i] ? (irq_in[i] && !m_prev[i]) : irq_in[i]);
      take   = pif.take_valid && (int'(pif.take_id) == i);
      pres   = m_pv && (m_pid == i);
      nst[i] = m_st[i];
      if (m_st[i] == 0) begin
        if (trig) nst[i] = 1;
      end else if (m_st[i] == 1) begin
        if (pres && acc) nst[i] = 2;
        else if (!src_enable[i] && !pres) nst[i] = 0;
        if (trig && edge_mode[i]) set_ovf = 1;
      end else begin
        if (take) nst[i] = trig ? 1 : 0;
        else if (trig && edge_mode[i]) set_ovf = 1;
      end
    end
    if (!m_pv || acc) begin
      found = 0; sel = 0;
      for (int k = 0; k < NS; k++) begin
        j = (m_rr + k) % NS;
        if (!found && m_st[j] == 1 && src_enable[j] && !(acc && j == m_pid)) begin
          found = 1; sel = j;
        end
      end
      if (found) begin
        m_pv = 1; m_pid = sel; m_rr = (sel + 1) % NS;
      end else begin
        m_pv = 0;
      end
    end
    if (set_ovf) m_ovf = 1;
    else if (ovf_clear) m_ovf = 0;
    for (int i = 0; i < NS; i++) begin
      m_st[i]   = nst[i];
      m_prev[i] = irq_in[i];
    end
  endtask

  task automatic compare_all();
    logic [NS-1:0] m_out;
    for (int i = 0; i < NS; i++) m_out[i] = (m_st[i] != 0);
    chk("pend_valid", pif.pend_valid, m_pv);
    chk("pend_id", pif.pend_id, m_pid);
    chk("overflow", overflow, m_ovf);
    chk("outstanding", outstanding, m_out);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic start_scn(input logic [NS-1:0] em);
    reset = 1'b1; irq_in = '0; edge_mode = em; src_enable = '1;
    ovf_clear = 1'b0; pif.pend_ready = 1'b1; pif.take_valid = 1'b0; pif.take_id = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic take(input int id);
    pif.take_valid = 1'b1; pif.take_id = IW'(id);
    tick();
    pif.take_valid = 1'b0;
  endtask

  initial begin
    int sid, st0;
    reset = 1'b1; irq_in = '0; edge_mode = '1; src_enable = '1; ovf_clear = 1'b0;
    pif.pend_ready = 1'b0; pif.take_valid = 1'b0; pif.take_id = '0;
    @(negedge clk);
    tick();
    chk("rst_pv", pif.pend_valid, 0);
    chk("rst_pid", pif.pend_id, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_out", outstanding, 0);

    // Single edge source, two-cycle latency, one-cycle request.
    start_scn('1);
    irq_in[3] = 1'b1; tick();
    chk("s1_req", outstanding[3], 1);
    chk("s1_pv_early", pif.pend_valid, 0);
    tick();
    chk("s1_pv", pif.pend_valid, 1);
    chk("s1_id", pif.pend_id, 3);
    tick();
    chk("s1_pv_drop", pif.pend_valid, 0);
    take(3);
    chk("s1_take", outstanding[3], 0);

    // Three simultaneous sources issue back to back.
    start_scn('1);
    irq_in = 8'b0110_0010; tick();
    tick(); chk("s2_id1", pif.pend_id, 1);
    tick(); chk("s2_id5", pif.pend_id, 5);
    tick(); chk("s2_id6", pif.pend_id, 6);
    tick(); chk("s2_idle", pif.pend_valid, 0);

    // Stalled handshake holds its id, next request follows without a bubble.
    start_scn('1);
    pif.pend_ready = 1'b0;
    irq_in = 8'b0001_0100; tick(); tick();
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("s3_hold", pif.pend_id, 2);
    end
    pif.pend_ready = 1'b1; tick();
    chk("s3_next_v", pif.pend_valid, 1);
    chk("s3_next_id", pif.pend_id, 4);
    tick();

    // Re-trigger while sent sets overflow; take plus edge re-requests cleanly.
    start_scn('1);
    irq_in[0] = 1'b1; tick(); tick(); tick();
    irq_in[0] = 1'b0; tick();
    irq_in[0] = 1'b1; tick();
    chk("s4_ovf", overflow, 1);
    chk("s4_pv", pif.pend_valid, 0);
    irq_in[0] = 1'b0; ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
    chk("s4_clr", overflow, 0);
    irq_in[0] = 1'b1; take(0);
    chk("s4_rereq", outstanding[0], 1);
    chk("s4_no_ovf", overflow, 0);
    tick();
    chk("s4_repend", pif.pend_id, 0);

    // Level source: held high pends once, re-pends after take, disable drops it.
    start_scn(8'b1110_1111);
    irq_in[4] = 1'b1; tick(); tick(); tick();
    tick(); tick();
    chk("s5_once", pif.pend_valid, 0);
    chk("s5_no_ovf", overflow, 0);
    take(4);
    chk("s5_pv_gap", pif.pend_valid, 0);
    tick();
    chk("s5_repend", pif.pend_valid, 1);
    tick();
    take(4);
    src_enable[4] = 1'b0; tick();
    chk("s5_dis_out", outstanding[4], 0);
    chk("s5_dis_pv", pif.pend_valid, 0);
    tick();
    src_enable[4] = 1'b1;

    // Reset in the middle of a handshake, lines still high afterwards.
    start_scn('1);
    pif.pend_ready = 1'b0;
    irq_in = 8'b0000_1110; tick(); tick();
    chk("s6_pv", pif.pend_valid, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("s6_rst_pv", pif.pend_valid, 0);
    chk("s6_rst_out", outstanding, 0);
    for (int c = 0; c < 3; c++) tick();
    chk("s6_quiet", pif.pend_valid, 0);

    // Randomized traffic.
    start_scn(NS'($urandom));
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 250 == 0) edge_mode = NS'($urandom);
      for (int i = 0; i < NS; i++) begin
        if ($urandom_range(0, 9) == 0) irq_in[i] = ~irq_in[i];
        if ($urandom_range(0, 49) == 0) src_enable[i] = ~src_enable[i];
      end
      pif.pend_ready = ($urandom_range(0, 9) < 7);
      ovf_clear      = ($urandom_range(0, 19) == 0);
      reset          = ($urandom_range(0, 599) == 0);
      pif.take_valid = 1'b0;
      if ($urandom_range(0, 2) == 0) begin
        pif.take_valid = 1'b1;
        pif.take_id    = IW'($urandom_range(0, NS - 1));
        st0 = $urandom_range(0, NS - 1);
        for (int k = 0; k < NS; k++) begin
          sid = (st0 + k) % NS;
          if (m_st[sid] == 2 && $urandom_range(0, 3) != 0) begin
            pif.take_id = IW'(sid);
            break;
          end
        end
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
